// File: rtl/matrix_word_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_word_serializer_if
// Description : Load and chunk-output handshake bundle for the word serializer.
// Revision    : 1.0
// ============================================================================
interface matrix_word_serializer_if #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 8
) ();
    logic                 load_valid;
    logic                 load_ready;
    logic [IN_WIDTH-1:0]  load_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    // slave: the serializer itself; master: the surrounding producer/consumer.
    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, out_data, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/matrix_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_word_serializer
// Description : Accepts one wide word and emits it MSB chunk first as
//               OUT_WIDTH-bit beats over a valid/ready handshake.
// Revision    : 1.0
// ============================================================================
module matrix_word_serializer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 8
) (
    input wire clock,
    input wire rst,
    matrix_word_serializer_if.slave bus
);
    localparam int NUM_CHUNKS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]          state_q,  state_d;
    logic [IN_WIDTH-1:0] shreg_q,  shreg_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [IN_WIDTH-1:0] shreg_shifted;
    logic                is_last;

    assign is_last = (state_q == SEND) && (count_q == LAST_CNT);

    // A single-chunk word has nothing below its top chunk to shift up.
    generate
        if (NUM_CHUNKS > 1) begin : g_shift
            assign shreg_shifted = {shreg_q[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
        end else begin : g_single
            assign shreg_shifted = '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    state_d = SEND;
                    shreg_d = bus.load_data;
                    count_d = '0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        shreg_d = '0;
                        count_d = '0;
                    end else begin
                        shreg_d = shreg_shifted;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.out_valid  = (state_q == SEND);
        bus.busy       = (state_q == SEND);
        bus.out_last   = is_last;
        bus.out_data   = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
    end
endmodule
`default_nettype wire

// File: tb/tb_matrix_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_word_serializer
// Description : Directed-vector bench for the 128/8 and 96/12 serializer builds.
// Revision    : 1.0
// ============================================================================
module tb_matrix_word_serializer;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    matrix_word_serializer_if #(.IN_WIDTH(128), .OUT_WIDTH(8))  bus8  ();
    matrix_word_serializer_if #(.IN_WIDTH(96),  .OUT_WIDTH(12)) bus12 ();

    matrix_word_serializer #(.IN_WIDTH(128), .OUT_WIDTH(8)) dut8 (
        .clock(clock), .rst(rst), .bus(bus8)
    );
    matrix_word_serializer #(.IN_WIDTH(96), .OUT_WIDTH(12)) dut12 (
        .clock(clock), .rst(rst), .bus(bus12)
    );

    // Reassembles the 8-bit stream back into a 128-bit word.
    logic [127:0] lb_q;
    always @(posedge clock)
        if (bus8.out_valid && bus8.out_ready) lb_q <= {lb_q[119:0], bus8.out_data};

    localparam logic [127:0] WORD_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] WORD_B = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load8(input logic [127:0] w);
        bus8.load_valid = 1'b1;
        bus8.load_data  = w;
        step();
        bus8.load_valid = 1'b0;
        bus8.load_data  = '0;
    endtask

    task automatic drain8(input string name, input logic [127:0] w);
        logic [127:0] wv;
        wv = w;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({bus8.out_valid, bus8.out_last, bus8.out_data} !== {1'b1, (i == 15), wv[127-8*i -: 8]}) begin
                miscompares++;
                $display("FAIL %s beat %0d: got valid/last/data=%b/%b/%h, want 1/%b/%h",
                         name, i, bus8.out_valid, bus8.out_last, bus8.out_data, (i == 15), wv[127-8*i -: 8]);
            end
            step();
        end
        vectors++;
        if ({bus8.load_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s idle after last: got ready/valid/busy=%b%b%b, want 100",
                     name, bus8.load_ready, bus8.out_valid, bus8.busy);
        end
    endtask

    task automatic test_reset();
        bus8.load_valid = 1'b0;  bus8.load_data  = '0; bus8.out_ready  = 1'b0;
        bus12.load_valid = 1'b0; bus12.load_data = '0; bus12.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({bus8.load_ready, bus8.out_valid, bus8.out_last, bus8.busy, bus8.out_data} !== {4'b1000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset8: got rdy/vld/last/busy/data=%b%b%b%b/%h, want 1000/00",
                     bus8.load_ready, bus8.out_valid, bus8.out_last, bus8.busy, bus8.out_data);
        end
        vectors++;
        if ({bus12.load_ready, bus12.out_valid, bus12.out_last, bus12.busy, bus12.out_data} !== {4'b1000, 12'h000}) begin
            miscompares++;
            $display("FAIL reset12: got rdy/vld/last/busy/data=%b%b%b%b/%h, want 1000/000",
                     bus12.load_ready, bus12.out_valid, bus12.out_last, bus12.busy, bus12.out_data);
        end
        bus8.out_ready = 1'b1;
        step();
        vectors++;
        if ({bus8.load_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_out_ready: got rdy/vld/busy=%b%b%b, want 100",
                     bus8.load_ready, bus8.out_valid, bus8.busy);
        end
    endtask

    task automatic test_straight();
        bus8.out_ready = 1'b1;
        load8(WORD_A);
        drain8("straight", WORD_A);
    endtask

    task automatic test_backpressure();
        logic [3:0]   pat;
        logic [127:0] wv;
        int idx;
        pat = 4'b1001;
        wv  = WORD_A;
        idx = 0;
        load8(WORD_A);
        for (int cyc = 0; cyc < 100 && idx < 16; cyc++) begin
            bus8.out_ready = pat[cyc % 4];
            vectors++;
            if ({bus8.out_valid, bus8.out_last, bus8.out_data} !== {1'b1, (idx == 15), wv[127-8*idx -: 8]}) begin
                miscompares++;
                $display("FAIL backpressure cyc %0d: got valid/last/data=%b/%b/%h, want 1/%b/%h",
                         cyc, bus8.out_valid, bus8.out_last, bus8.out_data, (idx == 15), wv[127-8*idx -: 8]);
            end
            if (bus8.out_ready) idx++;
            step();
        end
        vectors++;
        if (idx !== 16 || bus8.load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure beats: got %0d beats ready=%b, want 16 beats ready=1", idx, bus8.load_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] wv;
        wv = WORD_A;
        bus8.out_ready  = 1'b1;
        bus8.load_valid = 1'b1;
        bus8.load_data  = WORD_A;
        step();
        bus8.load_data  = WORD_B;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({bus8.out_valid, bus8.load_ready, bus8.out_last, bus8.out_data} !== {2'b10, (i == 15), wv[127-8*i -: 8]}) begin
                miscompares++;
                $display("FAIL b2b first beat %0d: got valid/ready/last/data=%b/%b/%b/%h, want 1/0/%b/%h",
                         i, bus8.out_valid, bus8.load_ready, bus8.out_last, bus8.out_data, (i == 15), wv[127-8*i -: 8]);
            end
            step();
        end
        vectors++;
        if ({bus8.load_ready, bus8.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b gap: got ready/valid=%b%b, want 10", bus8.load_ready, bus8.out_valid);
        end
        step();
        bus8.load_valid = 1'b0;
        bus8.load_data  = '0;
        drain8("b2b second", WORD_B);
    endtask

    task automatic test_reset_mid_send();
        bus8.out_ready = 1'b1;
        load8(WORD_B);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({bus8.out_valid, bus8.load_ready, bus8.busy, bus8.out_last, bus8.out_data} !== {4'b0100, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_reset: got vld/rdy/busy/last/data=%b%b%b%b/%h, want 0100/00",
                     bus8.out_valid, bus8.load_ready, bus8.busy, bus8.out_last, bus8.out_data);
        end
        load8(WORD_A);
        drain8("after_reset", WORD_A);
    endtask

    task automatic test_loopback();
        logic [127:0] w;
        logic         last_beat;
        bit           done;
        for (int n = 0; n < 50; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            bus8.out_ready = 1'($urandom_range(0, 1));
            load8(w);
            done = 1'b0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                bus8.out_ready = 1'($urandom_range(0, 1));
                last_beat = bus8.out_valid && bus8.out_ready && bus8.out_last;
                step();
                if (last_beat) done = 1'b1;
            end
            vectors++;
            if (!done || lb_q !== w) begin
                miscompares++;
                $display("FAIL loopback word %0d: done=%0d got %h, want %h", n, done, lb_q, w);
            end
        end
    endtask

    task automatic test_width96();
        logic [95:0] wv;
        wv = 96'hABC_DEF_012_345_678_9AB_CDE_F01;
        bus12.out_ready  = 1'b1;
        bus12.load_valid = 1'b1;
        bus12.load_data  = wv;
        step();
        bus12.load_valid = 1'b0;
        bus12.load_data  = '0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({bus12.out_valid, bus12.out_last, bus12.out_data} !== {1'b1, (i == 7), wv[95-12*i -: 12]}) begin
                miscompares++;
                $display("FAIL w96 beat %0d: got valid/last/data=%b/%b/%h, want 1/%b/%h",
                         i, bus12.out_valid, bus12.out_last, bus12.out_data, (i == 7), wv[95-12*i -: 12]);
            end
            step();
        end
        vectors++;
        if ({bus12.load_ready, bus12.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL w96 idle: got ready/valid=%b%b, want 10", bus12.load_ready, bus12.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_send();
        test_loopback();
        test_width96();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
